// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
// Used by the right shifter and the ALU decoder.
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = $clog2(WIDTH_DEF);

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Width of a stage index able to hold 0..sw-1.
  function automatic int stage_idx_w(input int sw);
    return (sw > 1) ? $clog2(sw) : 1;
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One conditional right-shift stage by 2^k.
// Vacated upper bits take the fill bit.
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int KW      = stage_idx_w(SHAMT_W)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_k,
  input  logic             i_en,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [SHAMT_W:0] w_amt;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_shr;

  // Shift by 2^k and OR the fill into the vacated top bits.
  always_comb begin
    w_amt  = (SHAMT_W+1)'(1) << i_k;
    w_mask = ~({WIDTH{1'b1}} >> w_amt);
    w_shr  = i_data >> w_amt;
    o_data = i_data;
    if (i_en) begin
      o_data = w_shr | (i_fill ? w_mask : '0);
    end
  end

endmodule

// File: rtl/right_shift_unit.sv
// Iterative right shifter: one binary stage per clock,
// largest stage first, valid/ready on both sides.
module right_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int KW = stage_idx_w(SHAMT_W);
  localparam logic [KW-1:0] K_TOP = KW'(SHAMT_W-1);

  state_t             r_state;
  state_t             w_next;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_out;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_fill;
  logic               r_valid;
  logic               w_accept;
  logic               w_bit;
  logic               w_last;
  logic [WIDTH-1:0]   w_stage;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out_valid = r_valid;
  assign out_data  = r_out;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_k == '0);
  assign w_bit    = |(r_shamt & (SHAMT_W'(1) << r_k));

  right_shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .KW      (KW)
  ) u_stage (
    .i_data (r_work),
    .i_k    (r_k),
    .i_en   (w_bit),
    .i_fill (r_fill),
    .o_data (w_stage)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_SHIFT : S_IDLE;
      S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, stage stepping and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= K_TOP;
      r_work  <= '0;
      r_out   <= '0;
      r_shamt <= '0;
      r_fill  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_work  <= in_data;
        r_shamt <= in_shamt;
        r_fill  <= (in_arith == SHIFT_ARITH) & in_data[WIDTH-1];
        r_k     <= K_TOP;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_stage;
        if (w_last) begin
          r_out   <= w_stage;
          r_valid <= 1'b1;
        end else begin
          r_k <= r_k - 1'b1;
        end
      end else if (r_state == S_DONE) begin
        if (out_ready) begin
          r_valid <= 1'b0;
          r_k     <= K_TOP;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_right_shift_unit.sv
// Bench for right_shift_unit: directed cases plus random
// operands against an arithmetic reference model.
module tb_right_shift_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  right_shift_unit #(
    .WIDTH   (W),
    .SHAMT_W (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shr(
    input logic [W-1:0] a,
    input int unsigned  sh,
    input logic         ar
  );
    logic signed [W-1:0] s;
    s = a;
    if (ar) return W'(s >>> sh);
    return a >> sh;
  endfunction

  task automatic send(input logic [W-1:0] a,
                      input logic [SW-1:0] sh,
                      input logic ar);
    @(negedge clk);
    in_data  = a;
    in_shamt = sh;
    in_arith = ar;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [SW-1:0] sh,
                        input logic ar,
                        input logic [W-1:0] exp,
                        input bit corrupt,
                        input int hold);
    int lat;
    send(a, sh, ar);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (corrupt) begin
        in_data  = $urandom;
        in_shamt = SW'($urandom);
        in_arith = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(SW));
    chk({tag, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_data  = $urandom;
      in_shamt = SW'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_d"}, out_data, exp);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_v"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0]  a;
    logic [SW-1:0] sh;
    logic          ar;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_d", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("lsr31", 32'h8000_0000, 5'd31, 1'b0,
           32'h0000_0001, 1'b0, 0);
    run_op("asr4", 32'h8000_0000, 5'd4, 1'b1,
           32'hF800_0000, 1'b0, 0);
    run_op("lsr4", 32'h8000_0000, 5'd4, 1'b0,
           32'h0800_0000, 1'b0, 0);
    run_op("z_l", 32'hDEAD_BEEF, 5'd0, 1'b0,
           32'hDEAD_BEEF, 1'b0, 0);
    run_op("z_a", 32'hDEAD_BEEF, 5'd0, 1'b1,
           32'hDEAD_BEEF, 1'b0, 0);
    run_op("pos31", 32'h7FFF_FFFF, 5'd31, 1'b1,
           32'h0000_0000, 1'b0, 0);
    run_op("bp", 32'hC000_1234, 5'd8, 1'b1,
           32'hFFC0_0012, 1'b0, 10);
    run_op("corrupt", 32'h9234_5678, 5'd13, 1'b1,
           ref_shr(32'h9234_5678, 13, 1'b1), 1'b1, 0);

    send(32'hFFFF_FFFF, 5'd3, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_d", out_data, 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h0000_F000, 5'd12, 1'b0,
           32'h0000_000F, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      sh = SW'($urandom);
      ar = 1'($urandom);
      run_op("rnd", a, sh, ar, ref_shr(a, int'(sh), ar),
             1'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
